// File: rtl/rr_input_queue_pkg.sv
// Shared sizing defaults and port-index type for the round-robin input queue and its arbiter.
package rr_pkg;
    localparam int unsigned RR_NUM_PORTS = 4;
    localparam int unsigned RR_DATA_W    = 8;
    localparam int unsigned RR_DEPTH     = 4;
    localparam int unsigned PORT_IDX_W   = 2;

    typedef logic [PORT_IDX_W-1:0] port_idx_t;
endpackage

// File: rtl/rr_input_queue_if.sv
// Requestor/arbiter/output bundle of the round-robin input queue.
interface rr_input_queue_if
    import rr_pkg::*;
#(
    parameter int unsigned NUM_PORTS = RR_NUM_PORTS,
    parameter int unsigned DATA_W    = RR_DATA_W
);
    logic                        enable;
    logic [NUM_PORTS-1:0]        in_valid;
    logic [NUM_PORTS*DATA_W-1:0] in_data;
    logic [NUM_PORTS-1:0]        in_ready;
    logic [NUM_PORTS-1:0]        req_vector;
    logic [NUM_PORTS-1:0]        grant_vector;
    logic                        out_valid;
    logic [DATA_W-1:0]           out_data;
    port_idx_t                   out_port;
    logic [NUM_PORTS-1:0]        ovf_flag;
    logic                        grant_err;

    modport master (
        output enable, in_valid, in_data, grant_vector,
        input  in_ready, req_vector, out_valid, out_data, out_port, ovf_flag, grant_err
    );

    modport slave (
        input  enable, in_valid, in_data, grant_vector,
        output in_ready, req_vector, out_valid, out_data, out_port, ovf_flag, grant_err
    );
endinterface

// File: rtl/rr_input_queue_fifo.sv
// Single per-port FIFO; caller guarantees push only when not full and pop only when not empty.
module rr_port_fifo
    import rr_pkg::*;
#(
    parameter int unsigned DATA_W = RR_DATA_W,
    parameter int unsigned DEPTH  = RR_DEPTH
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_head,
    output logic              o_empty,
    output logic              o_full
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;

    // Storage carries no reset; stale contents are unreachable once pointers clear.
    always_ff @(posedge i_clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CW'(DEPTH));
endmodule

// File: rtl/rr_input_queue.sv
// Per-port input queues feeding an external round-robin arbiter; forwards one granted head per cycle.
module rr_input_queue
    import rr_pkg::*;
#(
    parameter int unsigned NUM_PORTS = RR_NUM_PORTS,
    parameter int unsigned DATA_W    = RR_DATA_W,
    parameter int unsigned DEPTH     = RR_DEPTH
) (
    input  logic         i_clk,
    input  logic         i_rst,
    rr_input_queue_if.slave bus
);
    logic [NUM_PORTS-1:0] w_full;
    logic [NUM_PORTS-1:0] w_empty;
    logic [NUM_PORTS-1:0] w_push;
    logic [NUM_PORTS-1:0] w_pop;
    logic [NUM_PORTS-1:0] w_new_g;
    logic [NUM_PORTS-1:0] w_ovf_set;
    logic                 w_multi;
    logic [DATA_W-1:0]    w_head [NUM_PORTS];
    logic [DATA_W-1:0]    w_sel_data;
    port_idx_t            w_sel_port;

    logic [NUM_PORTS-1:0] r_grant_q;
    logic                 r_out_valid;
    logic [DATA_W-1:0]    r_out_data;
    port_idx_t            r_out_port;
    logic [NUM_PORTS-1:0] r_ovf;
    logic                 r_grant_err;

    // A write to a full port is dropped even if that port also pops this cycle.
    assign w_push    = bus.in_valid & ~w_full;
    assign w_ovf_set = bus.in_valid & w_full;
    assign w_new_g   = bus.grant_vector & ~r_grant_q;
    assign w_multi   = (bus.grant_vector & (bus.grant_vector - NUM_PORTS'(1))) != '0;
    assign w_pop     = {NUM_PORTS{bus.enable & ~w_multi}} & w_new_g & ~w_empty;

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_fifo
        rr_port_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_fifo (
            .i_clk   (i_clk),
            .i_rst   (i_rst),
            .i_push  (w_push[g]),
            .i_pop   (w_pop[g]),
            .i_data  (bus.in_data[g*DATA_W +: DATA_W]),
            .o_head  (w_head[g]),
            .o_empty (w_empty[g]),
            .o_full  (w_full[g])
        );
    end

    // Pop select; w_pop is at most one-hot because multi-bit grants are blocked.
    always_comb begin
        w_sel_data = '0;
        w_sel_port = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (w_pop[i]) begin
                w_sel_data = w_head[i];
                w_sel_port = port_idx_t'(i);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_grant_q   <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_port  <= '0;
            r_ovf       <= '0;
            r_grant_err <= 1'b0;
        end else begin
            r_grant_q   <= bus.grant_vector;
            r_out_valid <= |w_pop;
            if (|w_pop) begin
                r_out_data <= w_sel_data;
                r_out_port <= w_sel_port;
            end
            r_ovf       <= r_ovf | w_ovf_set;
            r_grant_err <= r_grant_err | w_multi;
        end
    end

    assign bus.in_ready   = ~w_full;
    assign bus.req_vector = {NUM_PORTS{bus.enable}} & ~w_empty;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_data   = r_out_data;
    assign bus.out_port   = r_out_port;
    assign bus.ovf_flag   = r_ovf;
    assign bus.grant_err  = r_grant_err;
endmodule

// File: tb/tb_rr_input_queue.sv
// Directed table-driven bench for rr_input_queue with hand-computed expectations.
module tb_rr_input_queue;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    rr_input_queue_if bus ();

    rr_input_queue u_dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    typedef struct {
        logic        en;
        logic [3:0]  v;
        logic [31:0] d;
        logic [3:0]  g;
        logic        ov;
        logic [7:0]  od;
        logic [1:0]  op;
        logic [3:0]  rdy;
        logic [3:0]  req;
        logic [3:0]  ovf;
        logic        gerr;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic en, input logic [3:0] v, input logic [31:0] d,
                       input logic [3:0] g, input logic ov, input logic [7:0] od,
                       input logic [1:0] op, input logic [3:0] rdy, input logic [3:0] req,
                       input logic [3:0] ovf, input logic gerr);
        vec_t r;
        r.en = en; r.v = v; r.d = d; r.g = g; r.ov = ov; r.od = od; r.op = op;
        r.rdy = rdy; r.req = req; r.ovf = ovf; r.gerr = gerr;
        vecs.push_back(r);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic en, input logic [3:0] v, input logic [31:0] d, input logic [3:0] g);
        bus.enable       = en;
        bus.in_valid     = v;
        bus.in_data      = d;
        bus.grant_vector = g;
    endtask

    task automatic check_all(input string tag, input logic ov, input logic [7:0] od, input logic [1:0] op,
                             input logic [3:0] rdy, input logic [3:0] req, input logic [3:0] ovf,
                             input logic gerr);
        check({tag, ".out_valid"},  32'(bus.out_valid),  32'(ov));
        check({tag, ".out_data"},   32'(bus.out_data),   32'(od));
        check({tag, ".out_port"},   32'(bus.out_port),   32'(op));
        check({tag, ".in_ready"},   32'(bus.in_ready),   32'(rdy));
        check({tag, ".req_vector"}, 32'(bus.req_vector), 32'(req));
        check({tag, ".ovf_flag"},   32'(bus.ovf_flag),   32'(ovf));
        check({tag, ".grant_err"},  32'(bus.grant_err),  32'(gerr));
    endtask

    initial begin
        bit found;

        //   en  valid    data          grant   ov  od     op    rdy      req      ovf      gerr
        add(1, 4'b0001, 32'h000000A1, 4'b0000, 0, 8'h00, 2'd0, 4'b1111, 4'b0001, 4'b0000, 0);
        add(1, 4'b0000, 32'h0,        4'b0001, 1, 8'hA1, 2'd0, 4'b1111, 4'b0000, 4'b0000, 0);
        add(1, 4'b0000, 32'h0,        4'b0001, 0, 8'hA1, 2'd0, 4'b1111, 4'b0000, 4'b0000, 0);
        add(1, 4'b0000, 32'h0,        4'b0000, 0, 8'hA1, 2'd0, 4'b1111, 4'b0000, 4'b0000, 0);
        add(1, 4'b0100, 32'h00110000, 4'b0000, 0, 8'hA1, 2'd0, 4'b1111, 4'b0100, 4'b0000, 0);
        add(1, 4'b0100, 32'h00120000, 4'b0000, 0, 8'hA1, 2'd0, 4'b1111, 4'b0100, 4'b0000, 0);
        add(1, 4'b0100, 32'h00130000, 4'b0000, 0, 8'hA1, 2'd0, 4'b1111, 4'b0100, 4'b0000, 0);
        add(1, 4'b0100, 32'h00140000, 4'b0000, 0, 8'hA1, 2'd0, 4'b1011, 4'b0100, 4'b0000, 0);
        add(1, 4'b0100, 32'h00150000, 4'b0000, 0, 8'hA1, 2'd0, 4'b1011, 4'b0100, 4'b0100, 0);
        add(1, 4'b0000, 32'h0,        4'b0100, 1, 8'h11, 2'd2, 4'b1111, 4'b0100, 4'b0100, 0);
        add(1, 4'b0000, 32'h0,        4'b0000, 0, 8'h11, 2'd2, 4'b1111, 4'b0100, 4'b0100, 0);
        add(1, 4'b0000, 32'h0,        4'b0100, 1, 8'h12, 2'd2, 4'b1111, 4'b0100, 4'b0100, 0);
        add(1, 4'b0000, 32'h0,        4'b0000, 0, 8'h12, 2'd2, 4'b1111, 4'b0100, 4'b0100, 0);
        add(1, 4'b0000, 32'h0,        4'b0100, 1, 8'h13, 2'd2, 4'b1111, 4'b0100, 4'b0100, 0);
        add(1, 4'b0000, 32'h0,        4'b0000, 0, 8'h13, 2'd2, 4'b1111, 4'b0100, 4'b0100, 0);
        add(1, 4'b0000, 32'h0,        4'b0100, 1, 8'h14, 2'd2, 4'b1111, 4'b0000, 4'b0100, 0);
        add(1, 4'b0000, 32'h0,        4'b0000, 0, 8'h14, 2'd2, 4'b1111, 4'b0000, 4'b0100, 0);
        add(1, 4'b0000, 32'h0,        4'b0100, 0, 8'h14, 2'd2, 4'b1111, 4'b0000, 4'b0100, 0);
        add(1, 4'b0000, 32'h0,        4'b0000, 0, 8'h14, 2'd2, 4'b1111, 4'b0000, 4'b0100, 0);
        add(1, 4'b1010, 32'h33002200, 4'b0000, 0, 8'h14, 2'd2, 4'b1111, 4'b1010, 4'b0100, 0);
        add(1, 4'b0000, 32'h0,        4'b0010, 1, 8'h22, 2'd1, 4'b1111, 4'b1000, 4'b0100, 0);
        add(1, 4'b0000, 32'h0,        4'b1000, 1, 8'h33, 2'd3, 4'b1111, 4'b0000, 4'b0100, 0);
        add(1, 4'b0000, 32'h0,        4'b0000, 0, 8'h33, 2'd3, 4'b1111, 4'b0000, 4'b0100, 0);
        add(1, 4'b1111, 32'h44434241, 4'b0000, 0, 8'h33, 2'd3, 4'b1111, 4'b1111, 4'b0100, 0);
        add(0, 4'b0000, 32'h0,        4'b0100, 0, 8'h33, 2'd3, 4'b1111, 4'b0000, 4'b0100, 0);
        add(0, 4'b0000, 32'h0,        4'b0000, 0, 8'h33, 2'd3, 4'b1111, 4'b0000, 4'b0100, 0);
        add(1, 4'b0000, 32'h0,        4'b0000, 0, 8'h33, 2'd3, 4'b1111, 4'b1111, 4'b0100, 0);
        add(1, 4'b0000, 32'h0,        4'b0110, 0, 8'h33, 2'd3, 4'b1111, 4'b1111, 4'b0100, 1);
        add(1, 4'b0000, 32'h0,        4'b0000, 0, 8'h33, 2'd3, 4'b1111, 4'b1111, 4'b0100, 1);
        add(1, 4'b0000, 32'h0,        4'b0001, 1, 8'h41, 2'd0, 4'b1111, 4'b1110, 4'b0100, 1);
        add(1, 4'b0010, 32'h00005500, 4'b0010, 1, 8'h42, 2'd1, 4'b1111, 4'b1110, 4'b0100, 1);
        add(1, 4'b0000, 32'h0,        4'b0000, 0, 8'h42, 2'd1, 4'b1111, 4'b1110, 4'b0100, 1);
        add(1, 4'b0000, 32'h0,        4'b0010, 1, 8'h55, 2'd1, 4'b1111, 4'b1100, 4'b0100, 1);
        add(1, 4'b1000, 32'h60000000, 4'b0000, 0, 8'h55, 2'd1, 4'b1111, 4'b1100, 4'b0100, 1);
        add(1, 4'b1000, 32'h61000000, 4'b0000, 0, 8'h55, 2'd1, 4'b1111, 4'b1100, 4'b0100, 1);
        add(1, 4'b1000, 32'h62000000, 4'b0000, 0, 8'h55, 2'd1, 4'b0111, 4'b1100, 4'b0100, 1);
        add(1, 4'b1000, 32'h63000000, 4'b1000, 1, 8'h44, 2'd3, 4'b1111, 4'b1100, 4'b1100, 1);
        add(1, 4'b0000, 32'h0,        4'b0000, 0, 8'h44, 2'd3, 4'b1111, 4'b1100, 4'b1100, 1);
        add(1, 4'b0000, 32'h0,        4'b1000, 1, 8'h60, 2'd3, 4'b1111, 4'b1100, 4'b1100, 1);

        rst = 1'b1;
        drive(1, 4'b0000, 32'h0, 4'b0000);
        tick();
        tick();
        rst = 1'b0;
        check_all("reset", 0, 8'h00, 2'd0, 4'b1111, 4'b0000, 4'b0000, 0);

        foreach (vecs[k]) begin
            drive(vecs[k].en, vecs[k].v, vecs[k].d, vecs[k].g);
            tick();
            check_all($sformatf("row%0d", k + 1), vecs[k].ov, vecs[k].od, vecs[k].op,
                      vecs[k].rdy, vecs[k].req, vecs[k].ovf, vecs[k].gerr);
        end

        // Mid-drain: pop port 2, then a one-cycle reset that also sees a push and a grant.
        drive(1, 4'b0000, 32'h0, 4'b0100);
        tick();
        check_all("drain", 1, 8'h43, 2'd2, 4'b1111, 4'b1000, 4'b1100, 1);
        rst = 1'b1;
        drive(1, 4'b0001, 32'h000000EE, 4'b1000);
        tick();
        rst = 1'b0;
        check_all("rst_mid", 0, 8'h00, 2'd0, 4'b1111, 4'b0000, 4'b0000, 0);
        drive(1, 4'b0000, 32'h0, 4'b0000);
        tick();
        check_all("post_rst", 0, 8'h00, 2'd0, 4'b1111, 4'b0000, 4'b0000, 0);

        // Fresh traffic after reset, waiting for the forwarded pulse within a bounded window.
        drive(1, 4'b0001, 32'h00000077, 4'b0000);
        tick();
        check("push77.req_vector", 32'(bus.req_vector), 32'h1);
        drive(1, 4'b0000, 32'h0, 4'b0001);
        found = 1'b0;
        for (int c = 0; c < 4 && !found; c++) begin
            tick();
            if (bus.out_valid) found = 1'b1;
        end
        check("pop77.seen", 32'(found), 32'h1);
        check("pop77.out_data", 32'(bus.out_data), 32'h77);
        check("pop77.out_port", 32'(bus.out_port), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rr_input_queue.md
RR_INPUT_QUEUE -- requirements
Module: rr_input_queue

Interface
REQ-001 Parameter NUM_PORTS, default 4: number of requestor ports; fixed at 4 in this revision.
REQ-002 Parameter DATA_W, default 8: payload width per port.
REQ-003 Parameter DEPTH, default 4: entries per port queue; SHALL be a power of two, at least 2.
REQ-004 CLK  input  1  single clock; all state updates on the rising edge.
REQ-005 RST  input  1  synchronous, active-high reset.
REQ-006 enable  input  1  active-high; when low, no requests are issued and no queue is popped.
REQ-007 in_valid  input  NUM_PORTS  per-port write strobe.
REQ-008 in_data  input  NUM_PORTS*DATA_W  packed payloads; port i occupies bits [i*DATA_W +: DATA_W].
REQ-009 in_ready  output  NUM_PORTS  per-port "not full".
REQ-010 req_vector  output  NUM_PORTS  per-port request to the round-robin arbiter.
REQ-011 grant_vector  input  NUM_PORTS  one-hot grant from the round-robin arbiter.
REQ-012 out_valid  output  1  one-cycle pulse marking a forwarded entry.
REQ-013 out_data  output  DATA_W  forwarded payload.
REQ-014 out_port  output  2  index of the source port of out_data.
REQ-015 ovf_flag  output  NUM_PORTS  sticky per-port overflow flag.
REQ-016 grant_err  output  1  sticky flag for an illegal, non-one-hot grant.

Function
REQ-017 Each port SHALL hold an independent FIFO of DEPTH entries; the occupancy count SHALL be clog2(DEPTH)+1 bits wide, and read/write pointers SHALL wrap modulo DEPTH.
REQ-018 in_ready[i] SHALL equal ~full[i], derived from registered state only.
REQ-019 A push SHALL occur when in_valid[i] & in_ready[i]; pushes SHALL be accepted regardless of enable.
REQ-020 in_valid[i] with full[i] SHALL drop the data and set ovf_flag[i]; this holds even if the same port pops in that cycle.
REQ-021 req_vector[i] SHALL equal enable & ~empty[i], derived from registered state.
REQ-022 A register grant_q SHALL capture grant_vector every cycle, independent of enable.
REQ-023 A new grant is new_g = grant_vector & ~grant_q, so a grant held for two cycles pops once.
REQ-024 If grant_vector has more than one bit set, no pop SHALL occur and grant_err SHALL set.
REQ-025 Port i SHALL pop when enable & new_g[i] & ~empty[i] and REQ-024 does not apply; a new grant to an empty port SHALL be ignored silently.
REQ-026 On a pop, out_valid SHALL be 1 in the following cycle, with out_data equal to the popped head and out_port equal to i (latency 1). Otherwise out_valid SHALL be 0, and out_data and out_port SHALL hold their last values.
REQ-027 A simultaneous push and pop on one non-full port SHALL leave the count unchanged and preserve FIFO order.
REQ-028 Pushing into an empty port SHALL not raise req_vector until the next cycle; no same-cycle bypass.

Reset
REQ-029 While RST=1 at a clock edge, all counts, pointers, grant_q, out_valid, out_data, out_port, ovf_flag and grant_err SHALL clear to 0; RST has priority over every push and pop in that cycle.
REQ-030 After reset, in_ready SHALL be all ones and req_vector all zeros.
REQ-031 Queue contents are discarded on reset and need no clearing.

Structure
REQ-032 A shared package rr_pkg SHALL hold NUM_PORTS, DATA_W, DEPTH defaults and the port-index type; the arbiter SHALL import the same package.
REQ-033 Sub-module rr_port_fifo (single FIFO: push, pop, head, empty, full) SHALL be instantiated NUM_PORTS times.
REQ-034 Grant edge detection, pop select and the output register SHALL live in rr_input_queue.

Verification
REQ-035 After reset, push 0xA1 on port 0, hold grant_vector=0001 for 2 cycles -> req_vector=0001, then a single out_valid pulse with out_data=0xA1, out_port=0; afterwards req_vector=0000.
REQ-036 Push 5 entries into port 2 back-to-back -> in_ready[2]=0 after the 4th, ovf_flag[2]=1; draining yields exactly the first 4 entries in order.
REQ-037 Load ports 1 and 3, then grant 0010 followed by 1000 -> out_valid on two consecutive cycles, out_port 1 then 3.
REQ-038 enable=0 with all ports non-empty, grant 0100 -> req_vector=0000, no out_valid, counts unchanged.
REQ-039 grant_vector=0110 -> no pop and grant_err=1; grant_err stays set until RST.
REQ-040 Assert RST for 1 cycle in the middle of draining -> next cycle out_valid=0, in_ready=1111, req_vector=0000, flags clear.
